// File: rtl/adc_frame_avg.sv
`default_nettype none
// ============================================================================
//  Module   : adc_frame_avg
//  Purpose  : Per-channel boxcar averager for a round-robin ADC stream; emits
//             one averaged word per channel per completed frame.
//  Revision : 1.0  initial release
// ============================================================================
module adc_frame_avg #(
    parameter int NUM_CH   = 6,
    parameter int AVG_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    input  logic [2:0]  sample_channel,
    input  logic        operation_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [2:0]  out_channel,
    output logic        out_last,
    output logic        seq_err,
    output logic        frame_drop,
    output logic        overflow,
    output logic [7:0]  seq_err_cnt
);

    localparam int               ACC_W      = 16 + AVG_LOG2;
    localparam int               RND_W      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [2:0]       c_LAST_CH  = 3'(NUM_CH - 1);
    localparam logic [RND_W-1:0] c_LAST_RND = RND_W'((1 << AVG_LOG2) - 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ACCUM    = 2'd1;
    localparam logic [1:0] c_RESYNC   = 2'd2;
    localparam logic       c_OUT_IDLE = 1'b0;
    localparam logic       c_OUT_SEND = 1'b1;

    logic [1:0]       r_in_state;
    logic [2:0]       r_exp_ch;
    logic [RND_W-1:0] r_round;
    logic [ACC_W-1:0] r_acc [NUM_CH];
    logic             r_frame_done;
    logic             r_seq_err;
    logic [7:0]       r_seq_err_cnt;

    logic             r_out_state;
    logic [2:0]       r_idx;
    logic [15:0]      r_out_buf [NUM_CH];
    logic             r_frame_drop;
    logic             r_overflow;

    logic [15:0]      w_avg [NUM_CH];
    logic             w_active;
    logic             w_accept;
    logic             w_mismatch;
    logic             w_ch_wrap;
    logic             w_frame_end;
    logic             w_hs;
    logic             w_hs_last;

    // RESYNC always waits with r_exp_ch == 0, so it shares the accept path.
    assign w_active    = (r_in_state == c_ACCUM) || (r_in_state == c_RESYNC);
    assign w_accept    = operation_mode && sample_valid && w_active && (sample_channel == r_exp_ch);
    assign w_mismatch  = operation_mode && sample_valid && (r_in_state == c_ACCUM) &&
                         (sample_channel != r_exp_ch);
    assign w_ch_wrap   = (r_exp_ch == c_LAST_CH);
    assign w_frame_end = w_accept && w_ch_wrap && (r_round == c_LAST_RND);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (r_round == '0)
                r_acc[r_exp_ch] <= ACC_W'(sample_data);
            else
                r_acc[r_exp_ch] <= r_acc[r_exp_ch] + ACC_W'(sample_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_state    <= c_IDLE;
            r_exp_ch      <= 3'd0;
            r_round       <= '0;
            r_frame_done  <= 1'b0;
            r_seq_err     <= 1'b0;
            r_seq_err_cnt <= 8'd0;
        end else begin
            r_frame_done <= w_frame_end;
            r_seq_err    <= w_mismatch;
            if (w_mismatch && (r_seq_err_cnt != 8'hFF))
                r_seq_err_cnt <= r_seq_err_cnt + 8'd1;

            if (!operation_mode) begin
                r_in_state <= c_IDLE;
                r_exp_ch   <= 3'd0;
                r_round    <= '0;
            end else begin
                case (r_in_state)
                    c_IDLE: begin
                        r_in_state <= c_ACCUM;
                        r_exp_ch   <= 3'd0;
                        r_round    <= '0;
                    end
                    c_ACCUM, c_RESYNC: begin
                        if (w_accept) begin
                            r_in_state <= c_ACCUM;
                            if (w_ch_wrap) begin
                                r_exp_ch <= 3'd0;
                                r_round  <= w_frame_end ? '0 : r_round + RND_W'(1);
                            end else begin
                                r_exp_ch <= r_exp_ch + 3'd1;
                            end
                        end else if (w_mismatch) begin
                            r_in_state <= c_RESYNC;
                            r_exp_ch   <= 3'd0;
                            r_round    <= '0;
                        end
                    end
                    default: r_in_state <= c_IDLE;
                endcase
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_avg
        assign w_avg[c] = r_acc[c][ACC_W-1:AVG_LOG2];
    end

    assign w_hs      = (r_out_state == c_OUT_SEND) && out_ready;
    assign w_hs_last = w_hs && (r_idx == c_LAST_CH);

    // A completed frame lands one edge after completion, so acc is already final
    // even if channel 0 of the next frame is being written on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_state  <= c_OUT_IDLE;
            r_idx        <= 3'd0;
            r_frame_drop <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_drop <= 1'b0;
            if (r_frame_done && ((r_out_state == c_OUT_IDLE) || w_hs_last)) begin
                for (int c = 0; c < NUM_CH; c++)
                    r_out_buf[c] <= w_avg[c];
                r_idx       <= 3'd0;
                r_out_state <= c_OUT_SEND;
            end else begin
                if (r_frame_done) begin
                    r_frame_drop <= 1'b1;
                    r_overflow   <= 1'b1;
                end
                if (w_hs_last) begin
                    r_idx       <= 3'd0;
                    r_out_state <= c_OUT_IDLE;
                end else if (w_hs) begin
                    r_idx <= r_idx + 3'd1;
                end
            end
        end
    end

    assign out_valid   = (r_out_state == c_OUT_SEND);
    assign out_data    = out_valid ? r_out_buf[r_idx] : 16'd0;
    assign out_channel = out_valid ? r_idx : 3'd0;
    assign out_last    = out_valid && (r_idx == c_LAST_CH);
    assign seq_err     = r_seq_err;
    assign frame_drop  = r_frame_drop;
    assign overflow    = r_overflow;
    assign seq_err_cnt = r_seq_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_avg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_frame_avg
//  Purpose  : Directed self-checking bench for adc_frame_avg (6 ch, 8-sample avg).
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_frame_avg;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic [2:0]  sample_channel;
    logic        operation_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_channel;
    logic        out_last;
    logic        seq_err;
    logic        frame_drop;
    logic        overflow;
    logic [7:0]  seq_err_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] exp_w [6];

    adc_frame_avg #(.NUM_CH(6), .AVG_LOG2(3)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .sample_channel (sample_channel),
        .operation_mode (operation_mode),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_channel    (out_channel),
        .out_last       (out_last),
        .seq_err        (seq_err),
        .frame_drop     (frame_drop),
        .overflow       (overflow),
        .seq_err_cnt    (seq_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // kind 0: 1000+c constant; kind 1: ch0 = r, ch c = 100c + r; kind 2: 0xFFFF
    function automatic logic [15:0] sdata(input int kind, input int r, input int c);
        if (kind == 0)      return 16'(1000 + c);
        else if (kind == 1) return (c == 0) ? 16'(r) : 16'(100 * c + r);
        else                return 16'hFFFF;
    endfunction

    task automatic set_exp(input int kind);
        for (int c = 0; c < 6; c++)
            exp_w[c] = (kind == 0) ? 16'(1000 + c) : (kind == 1) ? 16'(100 * c + 3) : 16'hFFFF;
    endtask

    task automatic send(input int ch, input logic [15:0] d);
        sample_valid   = 1'b1;
        sample_channel = 3'(ch);
        sample_data    = d;
        @(posedge clk);
        #1;
        sample_valid   = 1'b0;
    endtask

    task automatic send_samples(input int kind, input int first, input int count);
        for (int i = first; i < first + count; i++)
            send(i % 6, sdata(kind, i / 6, i % 6));
    endtask

    task automatic expect_frame(input int kind);
        int t;
        set_exp(kind);
        t = 0;
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("frame_valid", {31'd0, out_valid}, 32'd1);
        if (out_valid) begin
            for (int i = 0; i < 6; i++) begin
                check("out_channel", {29'd0, out_channel}, 32'(i));
                check("out_data", {16'd0, out_data}, {16'd0, exp_w[i]});
                check("out_last", {31'd0, out_last}, (i == 5) ? 32'd1 : 32'd0);
                out_ready = 1'b1;
                @(negedge clk);
            end
            check("valid_after_frame", {31'd0, out_valid}, 32'd0);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        sample_valid   = 1'b0;
        sample_data    = 16'd0;
        sample_channel = 3'd0;
        operation_mode = 1'b0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_cnt", {24'd0, seq_err_cnt}, 32'd0);
        check("rst_flags", {30'd0, seq_err, frame_drop}, 32'd0);

        // Normal frame with latency check (out_ready low keeps ch0 on the bus)
        operation_mode = 1'b1;
        @(posedge clk);
        #1;
        send_samples(0, 0, 48);
        @(negedge clk);
        check("lat_pre", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_post", {31'd0, out_valid}, 32'd1);
        expect_frame(0);

        // Averaging
        send_samples(1, 0, 48);
        expect_frame(1);
        send_samples(2, 0, 48);
        expect_frame(2);

        // Sequence error and resync
        send(0, 16'd11);
        send(1, 16'd22);
        send(3, 16'd33);
        @(negedge clk);
        check("seq_err_pulse", {31'd0, seq_err}, 32'd1);
        check("seq_err_cnt", {24'd0, seq_err_cnt}, 32'd1);
        @(negedge clk);
        check("seq_err_clear", {31'd0, seq_err}, 32'd0);
        send(4, 16'd44);
        send(5, 16'd55);
        @(negedge clk);
        check("resync_quiet", {31'd0, seq_err}, 32'd0);
        check("resync_cnt", {24'd0, seq_err_cnt}, 32'd1);
        check("resync_no_out", {31'd0, out_valid}, 32'd0);
        send_samples(0, 0, 48);
        expect_frame(0);

        // Backpressure across a second completion
        send_samples(0, 0, 48);
        repeat (2) @(negedge clk);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        send_samples(2, 0, 48);
        @(negedge clk);
        check("bp_drop_pre", {31'd0, frame_drop}, 32'd0);
        @(negedge clk);
        check("bp_drop", {31'd0, frame_drop}, 32'd1);
        check("bp_overflow", {31'd0, overflow}, 32'd1);
        check("bp_hold_data", {16'd0, out_data}, 32'd1000);
        check("bp_hold_ch", {29'd0, out_channel}, 32'd0);
        @(negedge clk);
        check("bp_drop_pulse", {31'd0, frame_drop}, 32'd0);
        check("bp_overflow_sticky", {31'd0, overflow}, 32'd1);
        expect_frame(0);
        repeat (5) @(negedge clk);
        check("bp_no_second", {31'd0, out_valid}, 32'd0);

        // Mode drop mid-frame
        send_samples(1, 0, 20);
        operation_mode = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        operation_mode = 1'b1;
        @(posedge clk);
        #1;
        send_samples(1, 0, 47);
        repeat (3) @(negedge clk);
        check("mode_no_early", {31'd0, out_valid}, 32'd0);
        send_samples(1, 47, 1);
        expect_frame(1);

        // Reset during output at idx 2
        send_samples(0, 0, 48);
        repeat (2) @(negedge clk);
        check("rs_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("rs_idx2_ch", {29'd0, out_channel}, 32'd2);
        check("rs_idx2_data", {16'd0, out_data}, 32'd1002);
        check("rs_pre_overflow", {31'd0, overflow}, 32'd1);
        check("rs_pre_cnt", {24'd0, seq_err_cnt}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rs_valid_low", {31'd0, out_valid}, 32'd0);
        check("rs_data_zero", {16'd0, out_data}, 32'd0);
        check("rs_overflow", {31'd0, overflow}, 32'd0);
        check("rs_cnt", {24'd0, seq_err_cnt}, 32'd0);
        repeat (10) @(negedge clk);
        check("rs_no_partial", {31'd0, out_valid}, 32'd0);
        send_samples(2, 0, 48);
        expect_frame(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_frame_avg.md
ADC_FRAME_AVG -- requirements
Module: adc_frame_avg

Interface
REQ-001 Parameter NUM_CH, default 6, meaning ADC channels per frame (channel codes 0..NUM_CH-1).
REQ-002 Parameter AVG_LOG2, default 3, meaning log2 of samples averaged per channel (N = 2^AVG_LOG2, AVG_LOG2 range 0..8).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sample_valid  input  1  one-cycle strobe, a 16-bit ADC word is present (driven by the serial-port controller's read strobe).
REQ-006 sample_data  input  16  unsigned ADC word, valid with sample_valid.
REQ-007 sample_channel  input  3  channel code of sample_data.
REQ-008 operation_mode  input  1  high while the ADC is in data mode; low = configuration.
REQ-009 out_valid  output  1  averaged word available.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  16  averaged value.
REQ-012 out_channel  output  3  channel of out_data.
REQ-013 out_last  output  1  high with the word for channel NUM_CH-1.
REQ-014 seq_err  output  1  one-cycle pulse, out-of-order channel detected.
REQ-015 frame_drop  output  1  one-cycle pulse, completed frame discarded.
REQ-016 overflow  output  1  sticky, set on any frame_drop.
REQ-017 seq_err_cnt  output  8  saturating count of seq_err pulses.

Function
REQ-018 Input FSM states: IDLE, ACCUM, RESYNC; output FSM states: OUT_IDLE, OUT_SEND.
REQ-019 operation_mode low forces the input FSM to IDLE on the next edge, clearing exp_ch and round; the output FSM is unaffected.
REQ-020 IDLE -> ACCUM when operation_mode is high; exp_ch = 0, round = 0.
REQ-021 ACCUM, sample_valid with sample_channel == exp_ch: acc[exp_ch] is loaded with sample_data if round == 0, else acc[exp_ch] += sample_data; acc width 16+AVG_LOG2, no overflow possible.
REQ-022 Accepted sample advances exp_ch; exp_ch wraps NUM_CH-1 -> 0 and increments round.
REQ-023 Sample with exp_ch == NUM_CH-1 and round == N-1 completes the frame; exp_ch and round return to 0; the FSM stays in ACCUM.
REQ-024 ACCUM, sample_valid with sample_channel != exp_ch: sample discarded, seq_err pulse, seq_err_cnt +1 (saturates at 255), -> RESYNC.
REQ-025 RESYNC: samples with channel != 0 ignored silently; a channel-0 sample is accepted as round 0 of a new frame (REQ-021) and the FSM goes to ACCUM.
REQ-026 sample_valid while the input FSM is in IDLE is ignored.
REQ-027 Frame completion at edge k: at edge k+1, if the output FSM is in OUT_IDLE, out_buf[c] = acc[c] >> AVG_LOG2 (truncation) for all c, idx = 0, -> OUT_SEND.
REQ-028 Frame completion while in OUT_SEND: frame discarded, frame_drop pulse, overflow set; the frame in progress is unaffected.
REQ-029 Exception: if the final handshake (idx = NUM_CH-1) occurs on the same edge as the load, the new frame is loaded (no drop).
REQ-030 OUT_SEND: out_valid = 1, out_channel = idx, out_data = out_buf[idx], out_last = (idx == NUM_CH-1).
REQ-031 Handshake on out_valid && out_ready: idx++; after the last word -> OUT_IDLE, out_valid low next cycle.
REQ-032 out_data, out_channel and out_last are held stable while out_valid && !out_ready.
REQ-033 out_valid, out_last, out_data and out_channel are 0 in OUT_IDLE.

Reset
REQ-034 rst high at an edge: both FSMs idle (IDLE/OUT_IDLE), exp_ch = round = idx = 0, all outputs 0, overflow = 0, seq_err_cnt = 0; accumulators need no reset.
REQ-035 Reset mid-frame or mid-output abandons all data; no partial frame is emitted afterwards.

Verification
REQ-036 Normal frame: 48 in-order samples, ch c value 1000+c -> 6 words 1000..1005, channels 0..5, out_last on ch 5, out_valid one edge after the 48th sample.
REQ-037 Averaging: ch0 values 0..7 over 8 rounds -> 3 (28>>3); all samples 0xFFFF -> 0xFFFF on every channel.
REQ-038 Sequence error: channels 0,1,3 -> seq_err pulse, seq_err_cnt = 1; samples ch4, ch5 ignored; a later full 48-sample run from ch0 -> correct frame.
REQ-039 Backpressure: out_ready = 0 through a second frame completion -> frame_drop pulse, overflow = 1, first-frame ch0 word held; releasing out_ready -> first frame only.
REQ-040 Mode drop: operation_mode low after 20 samples, then high -> no output until 48 further samples.
REQ-041 Reset during OUT_SEND at idx 2 -> out_valid = 0 next cycle, seq_err_cnt = 0, overflow = 0.
